gate_sequencer: RTL and testbench
=================================

// Module: gate_sequencer
// PURPOSE
//  Gate-window controller for the falling-edge pulse counter.
//  - Sequences the counter's enable (COLLECTING) and latch (LATCHING) inputs over a programmable gate of N clocks.
//  - Publishes each latched count to a downstream consumer over a valid/ready handshake.
//  - Supports single-shot and continuous framing, abort with counter flush, and a sticky overrun flag.
// PARAMETERS
//  GATE_W   16  width of gate_len and of the internal gate down-counter
//  FRAME_W  16  width of frame_id (used only with GATE_SEQ_FRAME_ID_EN)
// PORTS
//  clk          in   1        system clock; sole clock domain
//  reset        in   1        synchronous, active-high reset
//  start        in   1        begin a measurement; honoured only in IDLE
//  stop         in   1        abort or end measurement (see BEHAVIOUR)
//  continuous   in   1        sampled with start: 1 = back-to-back gates
//  gate_len     in   GATE_W   gate length in clocks, sampled with start
//  sample_ready in   1        consumer accepts the published sample
//  overrun_clr  in   1        clears the overrun flag
//  cnt_enable   out  1        drives pulse counter enable
//  cnt_latch    out  1        drives pulse counter latch
//  busy         out  1        high in every state except IDLE
//  sample_valid out  1        counter count_out holds an unconsumed sample
//  overrun      out  1        sticky: a sample was overwritten before acceptance
//  frame_id     out  FRAME_W  index of the published sample
// BEHAVIOUR
//  - Reset: state = IDLE. All outputs are 0, including frame_id and the frame counter. Reset mid-gate abandons the frame; the counter has its own reset.
//  - All outputs are registered. FSM states: IDLE, COLLECT, LATCH, FLUSH, HOLD.
//  - IDLE
//    - start=1 and stop=0: load gate_cnt = (gate_len==0 ? 1 : gate_len), register cont = continuous, go to COLLECT.
//    - start and stop both high: stop wins; remain in IDLE.
//  - COLLECT
//    - cnt_enable=1 for exactly gate_cnt cycles. The down-counter decrements each cycle.
//    - At count 1 with no stop, go to LATCH.
//  - LATCH
//    - cnt_latch=1 for exactly one cycle, with cnt_enable=0.
//    - Next state: cont=1 and stop=0 -> reload gate_len (re-sampled), go to COLLECT.
//    - Otherwise -> HOLD.
//  - Publish
//    - sample_valid rises on the cycle after LATCH, when count_out has updated.
//    - With the macro, frame_id updates on that same cycle.
//  - HOLD: wait until sample_valid=0, then go to IDLE. Also go to IDLE directly if already 0.
//  - stop in COLLECT: go to FLUSH.
//    - FLUSH asserts cnt_latch for one cycle to clear the partial count, then goes to IDLE.
//    - FLUSH does not publish: sample_valid and frame_id are unaffected, and no overrun is raised.
//    - stop in LATCH completes the publish, then enters HOLD.
//  - start while busy is ignored; a pending start is not queued.
//  - Latency: start accepted at cycle T ->
//    - cnt_enable high for T+1..T+L
//    - cnt_latch at T+L+1
//    - sample_valid at T+L+2
//    - continuous: next cnt_enable at T+L+2, giving period L+1.
//  - Handshake
//    - sample_valid clears the cycle after sample_valid and sample_ready are both high.
//    - A publish coinciding with an acceptance leaves sample_valid=1, holding the new sample.
//  - overrun
//    - Set when a publish occurs while sample_valid=1 and sample_ready=0.
//    - Cleared by overrun_clr; set wins over a simultaneous clear.
//  - gate_len=0 is treated as 1; the maximum is 2^GATE_W-1 with no wrap.
// CONFIGURATION
//  - GATE_SEQ_FRAME_ID_EN defined
//    - A FRAME_W-bit frame counter increments on every publish and wraps from 2^FRAME_W-1 to 0.
//    - frame_id presents the value of the published sample; the first sample is 0.
//    - FLUSH does not increment the counter.
//  - GATE_SEQ_FRAME_ID_EN undefined: frame_id is tied to 0 and no counter logic is built.
// TESTING
//  - Single-shot: start with gate_len=5 at T ->
//    - cnt_enable high for T+1..T+5
//    - cnt_latch at T+6
//    - sample_valid at T+7, held until sample_ready
//    - busy drops the cycle after acceptance.
//  - Continuous: gate_len=3, consumer always ready ->
//    - cnt_latch every 4 cycles; sample_valid pulses once per frame
//    - frame_id 0,1,2,3 (macro on); overrun stays 0.
//  - Overrun: continuous, gate_len=2, sample_ready=0 ->
//    - overrun=1 at the second publish; sample_valid stays 1.
//    - overrun_clr and a publish in the same cycle leave overrun=1.
//  - Abort: stop in the 3rd cycle of an 8-cycle gate ->
//    - one FLUSH cnt_latch, then IDLE
//    - sample_valid stays 0; frame_id is unchanged.
//  - Edge cases: gate_len=0 gives a 1-cycle enable.
//    - start with stop in IDLE: no activity.
//    - start while busy: ignored.
//    - reset mid-COLLECT: all outputs 0 next cycle.

Source files
------------

// File: rtl/gate_sequencer_if.sv
// Command/status bundle between a measurement controller and gate_sequencer.
// master drives commands and consumes samples; slave is the sequencer itself.
interface gate_sequencer_if #(
    parameter int GATE_W  = 16,
    parameter int FRAME_W = 16
) ();
    logic               start;
    logic               stop;
    logic               continuous;
    logic [GATE_W-1:0]  gate_len;
    logic               sample_ready;
    logic               overrun_clr;
    logic               cnt_enable;
    logic               cnt_latch;
    logic               busy;
    logic               sample_valid;
    logic               overrun;
    logic [FRAME_W-1:0] frame_id;

    modport master (
        output start, stop, continuous, gate_len, sample_ready, overrun_clr,
        input  cnt_enable, cnt_latch, busy, sample_valid, overrun, frame_id
    );

    modport slave (
        input  start, stop, continuous, gate_len, sample_ready, overrun_clr,
        output cnt_enable, cnt_latch, busy, sample_valid, overrun, frame_id
    );
endinterface

// File: rtl/gate_sequencer.sv
// Gate-window controller for the falling-edge pulse counter with sample handshake.
// Optional frame numbering is built only when GATE_SEQ_FRAME_ID_EN is defined.
module gate_sequencer #(
    parameter int GATE_W  = 16,
    parameter int FRAME_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    gate_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        LATCH,
        FLUSH,
        HOLD
    } state_e;

    state_e            state_q;
    logic [GATE_W-1:0] gateCnt_q;
    logic [GATE_W-1:0] gateLoad_d;
    logic              cont_q;
    logic              cntEnable_q;
    logic              cntLatch_q;
    logic              busy_q;
    logic              sampleValid_q;
    logic              sampleValid_d;
    logic              overrun_q;
    logic              overrun_d;
    logic              publish_d;

    // A publish overrides a same-cycle acceptance, and overrun set beats clear.
    always_comb begin
        gateLoad_d    = (bus.gate_len == '0) ? GATE_W'(1) : bus.gate_len;
        publish_d     = (state_q == LATCH);
        sampleValid_d = sampleValid_q;
        if (sampleValid_q && bus.sample_ready) begin
            sampleValid_d = 1'b0;
        end
        if (publish_d) begin
            sampleValid_d = 1'b1;
        end
        overrun_d = overrun_q;
        if (bus.overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (publish_d && sampleValid_q && !bus.sample_ready) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            gateCnt_q     <= '0;
            cont_q        <= 1'b0;
            cntEnable_q   <= 1'b0;
            cntLatch_q    <= 1'b0;
            busy_q        <= 1'b0;
            sampleValid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            sampleValid_q <= sampleValid_d;
            overrun_q     <= overrun_d;
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        gateCnt_q   <= gateLoad_d;
                        cont_q      <= bus.continuous;
                        cntEnable_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (bus.stop) begin
                        cntEnable_q <= 1'b0;
                        cntLatch_q  <= 1'b1;
                        state_q     <= FLUSH;
                    end else if (gateCnt_q == GATE_W'(1)) begin
                        cntEnable_q <= 1'b0;
                        cntLatch_q  <= 1'b1;
                        state_q     <= LATCH;
                    end else begin
                        gateCnt_q <= gateCnt_q - GATE_W'(1);
                    end
                end
                LATCH: begin
                    cntLatch_q <= 1'b0;
                    if (cont_q && !bus.stop) begin
                        gateCnt_q   <= gateLoad_d;
                        cntEnable_q <= 1'b1;
                        state_q     <= COLLECT;
                    end else begin
                        state_q <= HOLD;
                    end
                end
                FLUSH: begin
                    cntLatch_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                HOLD: begin
                    if (!sampleValid_d) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    cntEnable_q <= 1'b0;
                    cntLatch_q  <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.cnt_enable   = cntEnable_q;
    assign bus.cnt_latch    = cntLatch_q;
    assign bus.busy         = busy_q;
    assign bus.sample_valid = sampleValid_q;
    assign bus.overrun      = overrun_q;

`ifdef GATE_SEQ_FRAME_ID_EN
    logic [FRAME_W-1:0] frameCnt_q;
    logic [FRAME_W-1:0] frameId_q;

    // frame_id shows the number of the sample just published; flushes never count.
    always_ff @(posedge clk) begin
        if (reset) begin
            frameCnt_q <= '0;
            frameId_q  <= '0;
        end else if (publish_d) begin
            frameId_q  <= frameCnt_q;
            frameCnt_q <= frameCnt_q + FRAME_W'(1);
        end
    end

    assign bus.frame_id = frameId_q;
`else
    assign bus.frame_id = {FRAME_W{1'b0}};
`endif

endmodule

// File: tb/tb_gate_sequencer.sv
// Directed self-checking bench for gate_sequencer; outputs are sampled on the falling edge.
// Packed status vector order is {busy, cnt_enable, cnt_latch, sample_valid, overrun}.
module tb_gate_sequencer;

    logic clk;
    logic reset;
    int   testsRun;
    int   testsFailed;

    gate_sequencer_if #(.GATE_W(16), .FRAME_W(16)) bus ();

    gate_sequencer #(.GATE_W(16), .FRAME_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] outs;
    assign outs = {bus.busy, bus.cnt_enable, bus.cnt_latch, bus.sample_valid, bus.overrun};

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic sp, input logic ct,
                                 input logic [15:0] gl, input logic rdy, input logic clr);
        bus.start        = st;
        bus.stop         = sp;
        bus.continuous   = ct;
        bus.gate_len     = gl;
        bus.sample_ready = rdy;
        bus.overrun_clr  = clr;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [15:0] expFrame(input int k);
`ifdef GATE_SEQ_FRAME_ID_EN
        return 16'(k);
`else
        return 16'(k * 0);
`endif
    endfunction

    logic [4:0] ovTable [1:14];

    initial begin
        logic [4:0] e;
        testsRun    = 0;
        testsFailed = 0;
        reset       = 1'b1;
        applyStimulus(0, 0, 0, 16'd0, 0, 0);
        tick();
        tick();
        checkOutput("reset outs", 32'(outs), 32'h0);
        checkOutput("reset frame", 32'(bus.frame_id), 32'h0);
        reset = 1'b0;
        tick();

        // Single shot, gate 5, consumer accepts late
        applyStimulus(1, 0, 0, 16'd5, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 16'd5, 0, 0);
        for (int c = 1; c <= 10; c++) begin
            e = (c <= 5) ? 5'b11000 : (c == 6) ? 5'b10100 : 5'b10010;
            checkOutput($sformatf("single c%0d", c), 32'(outs), 32'(e));
            if (c == 10) applyStimulus(0, 0, 0, 16'd5, 1, 0);
            tick();
        end
        checkOutput("single accepted", 32'(outs), 32'h0);
        checkOutput("single frame", 32'(bus.frame_id), 32'(expFrame(0)));
        applyStimulus(0, 0, 0, 16'd0, 0, 0);

        // Abort in 3rd cycle of an 8-cycle gate
        applyStimulus(1, 0, 0, 16'd8, 0, 0);
        tick();
        for (int c = 1; c <= 6; c++) begin
            e = (c <= 3) ? 5'b11000 : (c == 4) ? 5'b10100 : 5'b00000;
            checkOutput($sformatf("abort c%0d", c), 32'(outs), 32'(e));
            applyStimulus(0, (c == 3), 0, 16'd8, 0, 0);
            tick();
        end
        checkOutput("abort frame", 32'(bus.frame_id), 32'(expFrame(0)));

        // gate_len 0 behaves as 1; frame counter untouched by the flush
        applyStimulus(1, 0, 0, 16'd0, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 16'd0, 1, 0);
        for (int c = 1; c <= 4; c++) begin
            e = (c == 1) ? 5'b11000 : (c == 2) ? 5'b10100 : (c == 3) ? 5'b10010 : 5'b00000;
            checkOutput($sformatf("gate0 c%0d", c), 32'(outs), 32'(e));
            if (c == 3) checkOutput("gate0 frame", 32'(bus.frame_id), 32'(expFrame(1)));
            tick();
        end

        // start together with stop in IDLE
        applyStimulus(1, 1, 0, 16'd5, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 16'd5, 0, 0);
        checkOutput("startstop c1", 32'(outs), 32'h0);
        tick();
        checkOutput("startstop c2", 32'(outs), 32'h0);

        // start while busy is ignored
        applyStimulus(1, 0, 0, 16'd4, 1, 0);
        tick();
        for (int c = 1; c <= 7; c++) begin
            e = (c <= 4) ? 5'b11000 : (c == 5) ? 5'b10100 : (c == 6) ? 5'b10010 : 5'b00000;
            checkOutput($sformatf("busystart c%0d", c), 32'(outs), 32'(e));
            applyStimulus((c == 2), 0, 0, 16'd1, 1, 0);
            tick();
        end

        // Reset mid-COLLECT
        applyStimulus(1, 0, 0, 16'd10, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 16'd10, 0, 0);
        for (int c = 1; c <= 3; c++) begin
            checkOutput($sformatf("rstmid c%0d", c), 32'(outs), 32'(5'b11000));
            if (c == 3) reset = 1'b1;
            tick();
        end
        checkOutput("rstmid outs", 32'(outs), 32'h0);
        checkOutput("rstmid frame", 32'(bus.frame_id), 32'h0);
        reset = 1'b0;
        tick();

        // Continuous, gate 3, consumer always ready, stopped mid-gate
        applyStimulus(1, 0, 1, 16'd3, 1, 0);
        tick();
        for (int c = 1; c <= 23; c++) begin
            if (c <= 21) begin
                e = {1'b1, ((c - 1) % 4 != 3), ((c - 1) % 4 == 3),
                     (c >= 5 && (c - 1) % 4 == 0), 1'b0};
            end else begin
                e = (c == 22) ? 5'b10100 : 5'b00000;
            end
            checkOutput($sformatf("cont c%0d", c), 32'(outs), 32'(e));
            if (c >= 5 && (c - 1) % 4 == 0)
                checkOutput($sformatf("cont frame c%0d", c), 32'(bus.frame_id),
                            32'(expFrame((c - 5) / 4)));
            applyStimulus(0, (c == 21), 1, 16'd3, 1, 0);
            tick();
        end

        // Overrun: continuous gate 2, consumer stalled, clear vs set race
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ovTable[1]  = 5'b11000; ovTable[2]  = 5'b11000; ovTable[3]  = 5'b10100;
        ovTable[4]  = 5'b11010; ovTable[5]  = 5'b11010; ovTable[6]  = 5'b10110;
        ovTable[7]  = 5'b11011; ovTable[8]  = 5'b11010; ovTable[9]  = 5'b10110;
        ovTable[10] = 5'b11011; ovTable[11] = 5'b10111; ovTable[12] = 5'b00011;
        ovTable[13] = 5'b00001; ovTable[14] = 5'b00000;
        applyStimulus(1, 0, 1, 16'd2, 0, 0);
        tick();
        for (int c = 1; c <= 14; c++) begin
            checkOutput($sformatf("overrun c%0d", c), 32'(outs), 32'(ovTable[c]));
            applyStimulus(0, (c == 10), 1, 16'd2, (c == 12),
                          (c == 7 || c == 9 || c == 13));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
